// File: rtl/tinyqv_data_router.sv
// Routes TinyQV CPU data accesses to one of NUM_CH channels selected by cpu_addr[SEL_LSB+2:SEL_LSB].
// Define TINYQV_ROUTER_TIMEOUT_EN to compile in the ACTIVE-state timeout that forces an error completion.
module tinyqv_data_router #(
   parameter int NUM_CH         = 4,
   parameter int SEL_LSB        = 25,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [27:0]           cpu_addr,
   input  logic [1:0]            cpu_write_n,
   input  logic [1:0]            cpu_read_n,
   input  logic                  cpu_read_complete,
   input  logic [31:0]           cpu_data_out,
   output logic                  cpu_data_ready,
   output logic [31:0]           cpu_data_in,
   output logic                  cpu_bus_error,
   output logic [27:0]           ch_addr,
   output logic [31:0]           ch_data_out,
   output logic [2*NUM_CH-1:0]   ch_write_n,
   output logic [2*NUM_CH-1:0]   ch_read_n,
   output logic [NUM_CH-1:0]     ch_read_complete,
   input  logic [NUM_CH-1:0]     ch_data_ready,
   input  logic [32*NUM_CH-1:0]  ch_data_in,
   output logic [7:0]            err_count
);

   typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

   state_t      state_q, state_d;
   logic [2:0]  sel_q, sel_d;
   logic [7:0]  errCount_q, errCount_d;
   logic        request, routeEn, errInc, timeoutHit;
   logic [2:0]  liveIdx, curIdx;
   logic        liveHit, chReady;
   logic [31:0] chData;

   assign request     = (cpu_write_n != 2'b11) || (cpu_read_n != 2'b11);
   assign liveIdx     = cpu_addr[SEL_LSB+2:SEL_LSB];
   // Once a transaction is accepted the latched index owns the bus, so address wobble is ignored.
   assign curIdx      = (state_q == ACTIVE) ? sel_q : liveIdx;
   assign ch_addr     = cpu_addr;
   assign ch_data_out = cpu_data_out;
   assign err_count   = errCount_q;
   assign errCount_d  = (errInc && (errCount_q != 8'hFF)) ? errCount_q + 8'd1 : errCount_q;

   always_comb begin
      liveHit = 1'b0;
      chReady = 1'b0;
      chData  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (liveIdx == 3'(k)) liveHit = 1'b1;
         if (curIdx == 3'(k)) begin
            chReady = ch_data_ready[k];
            chData  = ch_data_in[32*k +: 32];
         end
      end
   end

`ifdef TINYQV_ROUTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The acceptance cycle counts as the first one, so the first ACTIVE cycle sees 1.
   always_comb begin
      cnt_d = '0;
      if (state_d == ACTIVE) cnt_d = (state_q == ACTIVE) ? cnt_q + CNT_W'(1) : CNT_W'(1);
   end

   assign timeoutHit = (state_q == ACTIVE) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
`else
   // No timeout hardware: ACTIVE waits for the channel indefinitely.
   assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_d        = state_q;
      sel_d          = sel_q;
      routeEn        = 1'b0;
      errInc         = 1'b0;
      cpu_data_ready = 1'b0;
      cpu_bus_error  = 1'b0;
      cpu_data_in    = chData;
      case (state_q)
         IDLE: begin
            if (request) begin
               if (liveHit) begin
                  routeEn        = 1'b1;
                  cpu_data_ready = chReady;
                  sel_d          = liveIdx;
                  if (!chReady) state_d = ACTIVE;
               end else begin
                  cpu_data_in = '0;
                  state_d     = ERR;
               end
            end
         end
         ACTIVE: begin
            // A ready channel beats a coincident timeout.
            if (!request) begin
               state_d = IDLE;
            end else if (chReady) begin
               routeEn        = 1'b1;
               cpu_data_ready = 1'b1;
               state_d        = IDLE;
            end else if (timeoutHit) begin
               cpu_data_ready = 1'b1;
               cpu_bus_error  = 1'b1;
               cpu_data_in    = '1;
               errInc         = 1'b1;
               state_d        = IDLE;
            end else begin
               routeEn = 1'b1;
            end
         end
         ERR: begin
            cpu_data_ready = 1'b1;
            cpu_bus_error  = 1'b1;
            cpu_data_in    = '0;
            errInc         = 1'b1;
            state_d        = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) begin
         routeEn        = 1'b0;
         cpu_data_ready = 1'b0;
         cpu_bus_error  = 1'b0;
      end
   end

   always_comb begin
      ch_write_n       = '1;
      ch_read_n        = '1;
      ch_read_complete = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (routeEn && (curIdx == 3'(k))) begin
            ch_write_n[2*k +: 2] = cpu_write_n;
            ch_read_n[2*k +: 2]  = cpu_read_n;
         end
         if (!rst && (liveIdx == 3'(k))) ch_read_complete[k] = cpu_read_complete;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= '0;
         errCount_q <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         errCount_q <= errCount_d;
      end
   end

endmodule

// File: doc/tinyqv_data_router.md
TINYQV_DATA_ROUTER -- requirements
Module: tinyqv_data_router

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, the number of downstream channels (1..8).
REQ-002 SHALL have parameter SEL_LSB, default 25, the lowest address bit of the 3-bit channel index cpu_addr[SEL_LSB+2:SEL_LSB].
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the cycles a transaction may stay ACTIVE before forced completion.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, an asynchronous active-high reset.
REQ-006 SHALL have port cpu_addr, input, 28, the CPU data address.
REQ-007 SHALL have ports cpu_write_n and cpu_read_n, input, 2 each; 11 = idle, 00/01/10 = 8/16/32-bit.
REQ-008 SHALL have ports cpu_read_complete (input, 1), cpu_data_out (input, 32), cpu_data_ready (output, 1), cpu_data_in (output, 32) and cpu_bus_error (output, 1).
REQ-009 SHALL have ports ch_addr (output, 28) and ch_data_out (output, 32), which are cpu_addr and cpu_data_out broadcast unmodified.
REQ-010 SHALL have ports ch_write_n and ch_read_n (output, 2*NUM_CH each), ch_read_complete (output, NUM_CH), ch_data_ready (input, NUM_CH) and ch_data_in (input, 32*NUM_CH); channel k uses slice k.
REQ-011 SHALL have port err_count, output, 8, the saturating count of bus errors.

Function
REQ-012 SHALL implement FSM states IDLE, ACTIVE and ERR; a request is any cycle with cpu_write_n!=11 or cpu_read_n!=11.
REQ-013 In IDLE, the live index SHALL be decoded from cpu_addr; in ACTIVE, the index SHALL be the registered sel_q, so address changes mid-transaction are ignored.
REQ-014 IDLE with a request to an index < NUM_CH SHALL route the strobes to that channel in the same cycle (zero added latency), latch sel_q and enter ACTIVE unless the channel is ready that cycle.
REQ-015 Non-selected channels SHALL see write_n/read_n = 11 at all times.
REQ-016 cpu_data_ready and cpu_data_in SHALL be a combinational pass-through of the selected channel's ch_data_ready and ch_data_in; the cycle cpu_data_ready=1 completes the transaction and the next state is IDLE.
REQ-017 ACTIVE with a withdrawn request (both strobes 11) SHALL return to IDLE with no ready and the timeout counter cleared.
REQ-018 IDLE with a request to an index >= NUM_CH SHALL assert no channel strobes and enter ERR.
REQ-019 ERR SHALL last exactly 1 cycle with cpu_data_ready=1, cpu_bus_error=1 and cpu_data_in=0, then go to IDLE.
REQ-020 cpu_read_complete SHALL route to ch_read_complete of the live-decoded channel in every state, and to no channel if that index is unmapped.
REQ-021 cpu_bus_error SHALL be 0 except during error-completion cycles.
REQ-022 err_count SHALL increment by 1 per error completion and saturate at 255 with no wrap.
REQ-023 Outside IDLE, a new request SHALL NOT be accepted until the FSM returns to IDLE.

Reset
REQ-024 While rst=1: state=IDLE, sel_q=0, timeout counter=0, err_count=0.
REQ-025 While rst=1: all ch_write_n/ch_read_n=11, ch_read_complete=0, cpu_data_ready=0 and cpu_bus_error=0, regardless of inputs.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately, with no ready and no error recorded.

Configuration
REQ-027 Macro TINYQV_ROUTER_TIMEOUT_EN SHALL compile the timeout logic in or out.
REQ-028 With TINYQV_ROUTER_TIMEOUT_EN defined, a ceil(log2(TIMEOUT_CYCLES))-bit counter SHALL count ACTIVE cycles without ready.
REQ-029 With TINYQV_ROUTER_TIMEOUT_EN defined, in the cycle the counter equals TIMEOUT_CYCLES-1 (cycle count includes the IDLE acceptance cycle), the block SHALL: drive all channel strobes 11, assert cpu_data_ready=1 and cpu_bus_error=1, drive cpu_data_in=FFFFFFFF, increment err_count and go to IDLE.
REQ-030 With TINYQV_ROUTER_TIMEOUT_EN defined, a channel ready in the same cycle as the timeout SHALL win: normal completion, no error.
REQ-031 Without TINYQV_ROUTER_TIMEOUT_EN, no counter SHALL exist and ACTIVE SHALL wait indefinitely; errors come only from unmapped indices.

Verification
REQ-032 NUM_CH=4: 32-bit read at 0x2000010, ch_data_ready[1]=1 the same cycle with data 0xDEADBEEF -> cpu_data_ready=1 that cycle, cpu_data_in=0xDEADBEEF, no other channel strobed.
REQ-033 Write at 0x0000004, ch0 ready after 5 cycles, cpu_addr changed to 0x6000000 at cycle 2 -> ch0 keeps strobe 10 throughout, ch3 stays 11, completion at cycle 5.
REQ-034 Read at index 5 (0xA000000) with NUM_CH=4 -> no strobes, ready plus error one cycle later, cpu_data_in=0, err_count 0->1.
REQ-035 TINYQV_ROUTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ch2 never ready -> error ready on cycle 16, data FFFFFFFF; a repeat with ready on cycle 16 -> normal completion, err_count unchanged.
REQ-036 256 unmapped accesses followed by 1 more -> err_count holds 255.
REQ-037 rst pulsed during an ACTIVE ch1 read -> strobes 11 in the same cycle, no ready, IDLE after release.
